// File: rtl/reg_file_access_arbiter.sv
// ---------------------------------------------------------------------------
// reg_file_access_arbiter
//
// Purpose:
//   Shares a single 4x32 register file between port A (AXI4-Lite slave side)
//   and port B (local user logic). One access is in flight at a time. When both
//   ports request in the same IDLE cycle the winner is chosen round-robin, or
//   always A when FIXED_PRIORITY=1. Writes take two cycles (arbitrate, issue);
//   reads additionally capture the register-file data and hold it on the
//   winner's rdata/rvalid until the requester signals rready.
//
// Ports:
//   i_clock / i_aresetn           clock, asynchronous active-low reset
//   i_x_req/we/addr/wdata         request from port x (A or B), held until ack
//   o_x_ack                       one-cycle pulse when the access is issued
//   o_x_rdata / o_x_rvalid        read response, held until i_x_rready
//   i_x_rready                    read response accepted
//   o_rf_write_*                  register-file write strobe, address, data
//   o_rf_read_enable / _addr      register-file read strobe and address
//   i_rf_read_data                register-file data, valid one cycle after
//                                 the read strobe
//   o_grant                       {B,A} owner of the current transaction
//   o_busy                        high whenever a transaction is in progress
// ---------------------------------------------------------------------------
module reg_file_access_arbiter #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic                  i_clock,
  input  logic                  i_aresetn,

  input  logic                  i_a_req,
  input  logic                  i_a_we,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [DATA_WIDTH-1:0] i_a_wdata,
  output logic                  o_a_ack,
  output logic [DATA_WIDTH-1:0] o_a_rdata,
  output logic                  o_a_rvalid,
  input  logic                  i_a_rready,

  input  logic                  i_b_req,
  input  logic                  i_b_we,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  input  logic [DATA_WIDTH-1:0] i_b_wdata,
  output logic                  o_b_ack,
  output logic [DATA_WIDTH-1:0] o_b_rdata,
  output logic                  o_b_rvalid,
  input  logic                  i_b_rready,

  output logic                  o_rf_write_enable,
  output logic [ADDR_WIDTH-1:0] o_rf_write_addr,
  output logic [DATA_WIDTH-1:0] o_rf_write_data,
  output logic                  o_rf_read_enable,
  output logic [ADDR_WIDTH-1:0] o_rf_read_addr,
  input  logic [DATA_WIDTH-1:0] i_rf_read_data,

  output logic [1:0]            o_grant,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q;   // 0: A was granted last, 1: B
  logic [1:0]              grant_q;        // {B,A}
  logic                    hold_we_q;
  logic [ADDR_WIDTH-1:0]   hold_addr_q;
  logic [DATA_WIDTH-1:0]   hold_wdata_q;
  logic [DATA_WIDTH-1:0]   a_rdata_q, b_rdata_q;
  logic                    a_rvalid_q, b_rvalid_q;

  logic                    any_req;
  logic                    pick_b;
  logic                    win_rready;

  assign any_req = i_a_req | i_b_req;

  // B wins when it is alone, or on a tie in round-robin mode when A was the
  // previous owner. Reset leaves last_grant at B so A wins the first tie.
  assign pick_b = i_b_req &
                  (~i_a_req | ((FIXED_PRIORITY == 1'b0) & ~last_grant_q));

  assign win_rready = grant_q[1] ? i_b_rready : i_a_rready;

  // State register
  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (any_req) state_d = S_ISSUE;
      S_ISSUE:   state_d = hold_we_q ? S_IDLE : S_RD_WAIT;
      S_RD_WAIT: state_d = S_RESP;
      S_RESP:    if (win_rready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic: strobes and acks are single-cycle decodes of ISSUE
  always_comb begin
    o_a_ack           = (state_q == S_ISSUE) & grant_q[0];
    o_b_ack           = (state_q == S_ISSUE) & grant_q[1];
    o_rf_write_enable = (state_q == S_ISSUE) &  hold_we_q;
    o_rf_read_enable  = (state_q == S_ISSUE) & ~hold_we_q;
    o_busy            = (state_q != S_IDLE);
  end

  assign o_rf_write_addr = hold_addr_q;
  assign o_rf_write_data = hold_wdata_q;
  assign o_rf_read_addr  = hold_addr_q;
  assign o_grant         = grant_q;
  assign o_a_rdata       = a_rdata_q;
  assign o_b_rdata       = b_rdata_q;
  assign o_a_rvalid      = a_rvalid_q;
  assign o_b_rvalid      = b_rvalid_q;

  // Request capture, ownership and read-response registers
  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      last_grant_q <= 1'b1;
      grant_q      <= 2'b00;
      hold_we_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            last_grant_q <= pick_b;
            grant_q      <= pick_b ? 2'b10 : 2'b01;
            hold_we_q    <= pick_b ? i_b_we    : i_a_we;
            hold_addr_q  <= pick_b ? i_b_addr  : i_a_addr;
            hold_wdata_q <= pick_b ? i_b_wdata : i_a_wdata;
          end
        end
        S_ISSUE: begin
          if (hold_we_q) grant_q <= 2'b00;
        end
        S_RD_WAIT: begin
          if (grant_q[1]) begin
            b_rdata_q  <= i_rf_read_data;
            b_rvalid_q <= 1'b1;
          end else begin
            a_rdata_q  <= i_rf_read_data;
            a_rvalid_q <= 1'b1;
          end
        end
        S_RESP: begin
          if (win_rready) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            grant_q    <= 2'b00;
          end
        end
        default: begin
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_file_access_arbiter
//
// Two instances share all inputs: a round-robin arbiter (checked by a
// scoreboard of expected issues and read responses) and a fixed-priority
// arbiter (checked directly during the contention sequence). A small
// register-file model sits behind the round-robin instance.
// ---------------------------------------------------------------------------
module tb_reg_file_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_req = 0, a_we = 0, a_rready = 1;
  logic [3:0]  a_addr = 0;
  logic [31:0] a_wdata = 0;
  logic        b_req = 0, b_we = 0, b_rready = 1;
  logic [3:0]  b_addr = 0;
  logic [31:0] b_wdata = 0;
  logic [31:0] rf_rdata = 0;

  logic        a_ack, b_ack, a_rvalid, b_rvalid, we_en, re_en, busy;
  logic [31:0] a_rdata, b_rdata, wdata;
  logic [3:0]  waddr, raddr;
  logic [1:0]  grant;

  logic        fp_a_ack, fp_b_ack, fp_a_rvalid, fp_b_rvalid, fp_we_en, fp_re_en, fp_busy;
  logic [31:0] fp_a_rdata, fp_b_rdata, fp_wdata;
  logic [3:0]  fp_waddr, fp_raddr;
  logic [1:0]  fp_grant;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic        pb;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
  } ack_t;
  typedef struct packed {
    logic        pb;
    logic [31:0] data;
  } rd_t;

  ack_t ack_q[$];
  rd_t  rd_q[$];
  logic [31:0] mem [4];

  always #5 clk = ~clk;

  reg_file_access_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .FIXED_PRIORITY(1'b0)) dut (
    .i_clock(clk), .i_aresetn(rst_n),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_ack(a_ack), .o_a_rdata(a_rdata), .o_a_rvalid(a_rvalid), .i_a_rready(a_rready),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_ack(b_ack), .o_b_rdata(b_rdata), .o_b_rvalid(b_rvalid), .i_b_rready(b_rready),
    .o_rf_write_enable(we_en), .o_rf_write_addr(waddr), .o_rf_write_data(wdata),
    .o_rf_read_enable(re_en), .o_rf_read_addr(raddr), .i_rf_read_data(rf_rdata),
    .o_grant(grant), .o_busy(busy)
  );

  reg_file_access_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .FIXED_PRIORITY(1'b1)) dut_fp (
    .i_clock(clk), .i_aresetn(rst_n),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_ack(fp_a_ack), .o_a_rdata(fp_a_rdata), .o_a_rvalid(fp_a_rvalid), .i_a_rready(a_rready),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_ack(fp_b_ack), .o_b_rdata(fp_b_rdata), .o_b_rvalid(fp_b_rvalid), .i_b_rready(b_rready),
    .o_rf_write_enable(fp_we_en), .o_rf_write_addr(fp_waddr), .o_rf_write_data(fp_wdata),
    .o_rf_read_enable(fp_re_en), .o_rf_read_addr(fp_raddr), .i_rf_read_data(rf_rdata),
    .o_grant(fp_grant), .o_busy(fp_busy)
  );

  // Register-file model: write on the strobe, read data one cycle later
  always @(posedge clk) begin
    if (we_en) mem[waddr[1:0]] <= wdata;
    if (re_en) rf_rdata <= mem[raddr[1:0]];
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT issues or responds
  always @(negedge clk) begin
    if (rst_n) begin
      ack_t e;
      rd_t  r;
      check("strobe_overlap", {31'd0, we_en & re_en}, 32'd0);
      check("dual_ack", {31'd0, a_ack & b_ack}, 32'd0);
      check("dual_rvalid", {31'd0, a_rvalid & b_rvalid}, 32'd0);
      if (a_ack | b_ack | we_en | re_en) begin
        if (ack_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_issue: got ack=%b%b we=%b re=%b expected none", b_ack, a_ack, we_en, re_en);
        end else begin
          e = ack_q.pop_front();
          $display("issue: port=%s we=%0d addr=%0d data=%h", e.pb ? "B" : "A", e.we, e.addr, e.data);
          check("ack_port", {30'd0, b_ack, a_ack}, e.pb ? 32'd2 : 32'd1);
          check("rf_strobe", {30'd0, we_en, re_en}, e.we ? 32'd2 : 32'd1);
          check("rf_addr", {28'd0, e.we ? waddr : raddr}, {28'd0, e.addr});
          if (e.we) check("rf_wdata", wdata, e.data);
        end
      end
      if ((a_rvalid & a_rready) | (b_rvalid & b_rready)) begin
        if (rd_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rvalid: got rvalid=%b%b expected none", b_rvalid, a_rvalid);
        end else begin
          r = rd_q.pop_front();
          $display("read resp: port=%s data=%h", r.pb ? "B" : "A", r.pb ? b_rdata : a_rdata);
          check("rvalid_port", {30'd0, b_rvalid, a_rvalid}, r.pb ? 32'd2 : 32'd1);
          check("rdata", r.pb ? b_rdata : a_rdata, r.data);
        end
      end
    end
  end

  task automatic issue(input logic pb, input logic we, input logic [3:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    if (!pb) begin a_req = 1; a_we = we; a_addr = addr; a_wdata = data; end
    else     begin b_req = 1; b_we = we; b_addr = addr; b_wdata = data; end
    ack_q.push_back({pb, we, addr, data});
  endtask

  task automatic drop(input logic pb);
    if (!pb) a_req = 0; else b_req = 0;
  endtask

  task automatic do_write(input logic pb, input logic [3:0] addr, input logic [31:0] data);
    issue(pb, 1'b1, addr, data);
    @(negedge clk);
    check("wr_busy_c0", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("wr_ack_c1", {31'd0, pb ? b_ack : a_ack}, 32'd1);
    check("wr_en_c1", {31'd0, we_en}, 32'd1);
    drop(pb);
    @(negedge clk);
    check("wr_busy_c2", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_read(input logic pb, input logic [3:0] addr, input logic [31:0] exp);
    issue(pb, 1'b0, addr, 32'd0);
    rd_q.push_back({pb, exp});
    @(negedge clk);
    @(negedge clk);
    check("rd_ack_c1", {31'd0, pb ? b_ack : a_ack}, 32'd1);
    drop(pb);
    @(negedge clk);
    check("rd_rvalid_c2", {31'd0, pb ? b_rvalid : a_rvalid}, 32'd0);
    @(negedge clk);
    check("rd_rvalid_c3", {31'd0, pb ? b_rvalid : a_rvalid}, 32'd1);
    check("rd_rdata_c3", pb ? b_rdata : a_rdata, exp);
    @(negedge clk);
    check("rd_busy_c4", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_strobes", {30'd0, we_en, re_en}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;

    // Single write by A, single read by B
    do_write(1'b0, 4'd2, 32'hDEADBEEF);
    do_read(1'b1, 4'd2, 32'hDEADBEEF);

    // Contention: both ports hold write requests for four transactions
    @(posedge clk); #1;
    a_req = 1; a_we = 1; a_addr = 4'd0; a_wdata = 32'h11;
    b_req = 1; b_we = 1; b_addr = 4'd1; b_wdata = 32'h22;
    ack_q.push_back({1'b0, 1'b1, 4'd0, 32'h11});
    ack_q.push_back({1'b1, 1'b1, 4'd1, 32'h22});
    ack_q.push_back({1'b0, 1'b1, 4'd0, 32'h11});
    ack_q.push_back({1'b1, 1'b1, 4'd1, 32'h22});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i % 2 == 1) begin
        check("rr_grant", {30'd0, grant}, (i % 4 == 1) ? 32'd1 : 32'd2);
        check("fp_grant", {30'd0, fp_grant}, 32'd1);
        check("fp_a_ack", {31'd0, fp_a_ack}, 32'd1);
        check("fp_waddr", {28'd0, fp_waddr}, 32'd0);
      end
      if (i == 7) begin a_req = 0; b_req = 0; end
    end
    @(negedge clk);
    check("contend_busy", {31'd0, busy}, 32'd0);
    check("contend_fp_busy", {31'd0, fp_busy}, 32'd0);

    // Backpressure: A read held for five cycles, B write waits behind it
    @(posedge clk); #1;
    a_rready = 0;
    issue(1'b0, 1'b0, 4'd0, 32'd0);
    rd_q.push_back({1'b0, 32'h11});
    @(negedge clk);
    @(negedge clk);
    check("bp_ack", {31'd0, a_ack}, 32'd1);
    a_req = 0;
    b_req = 1; b_we = 1; b_addr = 4'd1; b_wdata = 32'h33;
    ack_q.push_back({1'b1, 1'b1, 4'd1, 32'h33});
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rvalid", {31'd0, a_rvalid}, 32'd1);
      check("bp_rdata", a_rdata, 32'h11);
      check("bp_busy", {31'd0, busy}, 32'd1);
      check("bp_b_ack", {31'd0, b_ack}, 32'd0);
      check("bp_grant", {30'd0, grant}, 32'd1);
    end
    @(posedge clk); #1;
    a_rready = 1;
    @(negedge clk);
    @(negedge clk);
    check("bp_rvalid_clr", {31'd0, a_rvalid}, 32'd0);
    @(negedge clk);
    check("bp_b_granted", {31'd0, b_ack}, 32'd1);
    b_req = 0;
    @(negedge clk);
    check("bp_idle", {31'd0, busy}, 32'd0);

    // Reset during RD_WAIT, then a tie must go to A first
    issue(1'b0, 1'b0, 4'd1, 32'd0);
    @(negedge clk);
    @(negedge clk);
    a_req = 0;
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_rvalid", {30'd0, b_rvalid, a_rvalid}, 32'd0);
    check("mr_rdata_a", a_rdata, 32'd0);
    check("mr_grant", {30'd0, grant}, 32'd0);
    check("mr_strobes", {28'd0, we_en, re_en, a_ack, b_ack}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    a_req = 1; a_we = 1; a_addr = 4'd2; a_wdata = 32'h44;
    b_req = 1; b_we = 1; b_addr = 4'd3; b_wdata = 32'h55;
    ack_q.push_back({1'b0, 1'b1, 4'd2, 32'h44});
    ack_q.push_back({1'b1, 1'b1, 4'd3, 32'h55});
    @(negedge clk);
    @(negedge clk);
    check("mr_tie_a_ack", {31'd0, a_ack}, 32'd1);
    a_req = 0;
    @(negedge clk);
    @(negedge clk);
    check("mr_tie_b_ack", {31'd0, b_ack}, 32'd1);
    b_req = 0;
    @(negedge clk);

    // Write-then-read across ports
    do_write(1'b0, 4'd3, 32'hCAFEF00D);
    do_read(1'b1, 4'd3, 32'hCAFEF00D);

    @(negedge clk);
    check("ack_q_drained", ack_q.size(), 32'd0);
    check("rd_q_drained", rd_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
